// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared-register arbiter slice.
// Consumed by shared_reg_arbiter and shared_reg8.
package shared_reg_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned HOLD_W  = 4;

  localparam logic [HOLD_W-1:0] HOLD_MAX = 4'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] idx;
  } pick_t;

  // First set request bit at or above ptr, wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [PTR_W-1:0]   ptr);
    pick_t            p;
    logic [PTR_W-1:0] idx;
    p = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr + k[PTR_W-1:0];
      if (req[idx] && !p.vld) begin
        p.vld = 1'b1;
        p.idx = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/shared_reg8.sv
// Load-enabled storage register with async active-high reset.
// qb is always the bitwise complement of q.
module shared_reg8
  import shared_reg_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] qb
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared 8-bit register.
// Optional forced grant revocation after a hold limit: define ARB_TIMEOUT_EN.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic [DATA_W-1:0]         qb,
  output logic                      timeout
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  r_holder;
  logic [PTR_W-1:0]  w_holder_nxt;
  pick_t             w_pick;
  logic              w_hold_req;
  logic              w_force;
  logic              w_load;
  logic [DATA_W-1:0] w_wdata;

  assign w_pick     = rr_pick(req, r_ptr);
  assign w_hold_req = req[r_holder];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  // Counter sits at zero throughout IDLE, so it is already cleared on GRANT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout  <= w_force;
      if (r_state == ST_GRANT) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign w_force = (r_state == ST_GRANT) && w_hold_req && (r_hold_cnt == HOLD_MAX);
  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_holder <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_holder <= w_holder_nxt;
    end
  end

  // Release always passes through IDLE, so hand-over never happens on one edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_holder_nxt = r_holder;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick.vld) begin
          w_state_nxt  = ST_GRANT;
          w_holder_nxt = w_pick.idx;
        end
      end
      ST_GRANT: begin
        if (!w_hold_req || w_force) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_holder + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt     = '0;
    w_load  = 1'b0;
    w_wdata = wr_data[r_holder*DATA_W +: DATA_W];
    if (r_state == ST_GRANT) begin
      gnt[r_holder] = 1'b1;
      w_load        = w_hold_req && wr_en[r_holder] && !w_force;
    end
  end

  shared_reg8 u_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_d    (w_wdata),
    .q      (q),
    .qb     (qb)
  );

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter.
// The hold-limit scenario is exercised when ARB_TIMEOUT_EN is defined.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic        timeout;

  int unsigned n_tests;
  int unsigned n_fail;

  shared_reg_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
    .qb      (qb),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    req   = '0;
    wr_en = '0;
    #2;
    rst   = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = '0;
    wr_en   = '0;
    wr_data = '0;

    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q",   32'(q),   32'h00);
    check("rst_qb",  32'(qb),  32'hFF);
    check("rst_to",  32'(timeout), 32'h0);
    #2;
    rst = 1'b0;

    // Idle with no requests; stray wr_en must not touch q
    wr_en   = 4'hF;
    wr_data = 32'h1122_3344;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_q",   32'(q),   32'h00);
      check("idle_qb",  32'(qb),  32'hFF);
    end
    wr_en = '0;

    // First grant from ptr 0, release, one IDLE cycle, then requester 2
    req = 4'b0101;
    tick();
    check("g0101_first", 32'(gnt), 32'h1);
    req = 4'b0100;
    tick();
    check("g0101_gap", 32'(gnt), 32'h0);
    tick();
    check("g0101_second", 32'(gnt), 32'h4);

    // Granted holder 2 writes; lane 1 strobe ignored
    wr_en   = 4'b0110;
    wr_data = 32'h00A5_3C00;
    tick();
    check("wr_q",  32'(q),  32'hA5);
    check("wr_qb", 32'(qb), 32'h5A);
    check("wr_gnt_hold", 32'(gnt), 32'h4);

    wr_en   = 4'b0010;
    wr_data = 32'h0000_7700;
    tick();
    check("nongrant_wr_q", 32'(q), 32'hA5);

    // Release with simultaneous write: release wins
    req     = 4'b0000;
    wr_en   = 4'b0100;
    wr_data = 32'h00FF_0000;
    tick();
    check("rel_wr_gnt", 32'(gnt), 32'h0);
    check("rel_wr_q",   32'(q),   32'hA5);
    wr_en = '0;

    // Round robin through all requesters and the 3 -> 0 wrap
    apply_reset();
    #1;
    check("rr_rst_q", 32'(q), 32'h00);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      tick();
      check("rr_grant", 32'(gnt), 32'(exp_g));
      tick();
      check("rr_hold", 32'(gnt), 32'(exp_g));
      req[k % 4] = 1'b0;
      tick();
      check("rr_gap", 32'(gnt), 32'h0);
      req = 4'hF;
    end

    // Async reset mid-grant aborts a pending write
    apply_reset();
    req = 4'b1000;
    tick();
    check("g3_grant", 32'(gnt), 32'h8);
    wr_en   = 4'b1000;
    wr_data = 32'h5A00_0000;
    tick();
    check("g3_wr_q", 32'(q), 32'h5A);
    wr_data = 32'hC300_0000;
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_q",   32'(q),   32'h00);
    check("arst_qb",  32'(qb),  32'hFF);
    req   = '0;
    wr_en = '0;
    #1;
    rst = 1'b0;
    tick();
    check("arst_after_q", 32'(q), 32'h00);

    apply_reset();
    req = 4'b0011;
    tick();
    check("hold_grant", 32'(gnt), 32'h1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h1);
      check("hold_to",  32'(timeout), 32'h0);
    end
    wr_en   = 4'b0001;
    wr_data = 32'h0000_00EE;
    tick();
    check("force_gnt", 32'(gnt), 32'h0);
    check("force_to",  32'(timeout), 32'h1);
    check("force_q",   32'(q), 32'h00);
    wr_en = '0;
    tick();
    check("after_force_gnt", 32'(gnt), 32'h2);
    check("after_force_to",  32'(timeout), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_gnt", 32'(gnt), 32'h1);
      check("hold_to",  32'(timeout), 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port req, input, 4, per-requester access request, level, bit i = requester i.
REQ-004 SHALL have port wr_en, input, 4, per-requester write strobe, honoured only for the granted requester.
REQ-005 SHALL have port wr_data, input, 32, packed write data, bits [8i+7:8i] belong to requester i.
REQ-006 SHALL have port gnt, input-to-requesters output, 4, one-hot-or-zero grant vector.
REQ-007 SHALL have port q, output, 8, shared register contents.
REQ-008 SHALL have port qb, output, 8, bitwise complement of q at all times.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse on forced grant revocation.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-011 IDLE with req!=0: SHALL enter GRANT at next edge, granting first set req bit searching upward (mod 4) from pointer ptr.
REQ-012 IDLE with req=0: SHALL stay IDLE; ptr unchanged.
REQ-013 GRANT while holder's req bit high: SHALL hold gnt unchanged; other req bits ignored.
REQ-014 GRANT when holder's req bit low at an edge: SHALL return to IDLE (gnt=0) and set ptr=(holder+1) mod 4.
REQ-015 SHALL guarantee at least one IDLE cycle between consecutive grants; no same-edge hand-over.
REQ-016 Write: when gnt[i] and wr_en[i] are high at an edge, q SHALL load wr_data[8i+7:8i] at that edge (one-cycle latency).
REQ-017 wr_en of non-granted requesters, and any wr_en in IDLE, SHALL be ignored; q holds.
REQ-018 Holder dropping req and asserting wr_en at same edge: write SHALL be ignored (release wins).
REQ-019 ptr SHALL be 2 bits and wrap 3 -> 0.

Reset
REQ-020 rst high SHALL immediately force: state IDLE, gnt=0, q=8'h00, qb=8'hFF, ptr=0, hold counter 0, timeout=0.
REQ-021 rst asserted mid-grant SHALL abort the grant without completing any pending write.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined: a 4-bit hold counter SHALL clear on entering GRANT and increment each GRANT cycle; on the edge where it equals 15 and holder's req is still high, FSM SHALL go IDLE, ptr=(holder+1) mod 4, and timeout SHALL pulse high for exactly one cycle.
REQ-023 Forced-release edge SHALL ignore any wr_en from the holder.
REQ-024 Without ARB_TIMEOUT_EN: no counter, grants held indefinitely, timeout tied to 0.

Structure
REQ-025 Shared package SHALL hold the FSM state typedef (IDLE, GRANT), NUM_REQ=4, DATA_W=8, HOLD_MAX=15.
REQ-026 The storage register SHALL be a sub-module shared_reg8 (8 D flip-flops with load enable, async active-high reset, q/qb outputs).
REQ-027 Round-robin select SHALL be combinational logic within shared_reg_arbiter.

Verification
REQ-028 Reset then req=4'b0000 for 10 cycles -> gnt=0, q=8'h00, qb=8'hFF throughout.
REQ-029 req=4'b0101 from reset -> gnt=4'b0001 one edge later; drop req[0] -> gnt=0 for one cycle, then gnt=4'b0100.
REQ-030 Holder 2 granted, wr_en=4'b0110, wr_data lane2=8'hA5, lane1=8'h3C -> q=8'hA5, qb=8'h5A next cycle.
REQ-031 All four req held, each releasing after 2 cycles -> grant order 0,1,2,3,0.
REQ-032 ARB_TIMEOUT_EN, req=4'b0011 held constantly -> holder 0 revoked after 16 GRANT cycles, timeout pulses once, gnt=4'b0010 after one IDLE cycle.
REQ-033 rst pulsed while gnt=4'b1000 and wr_en[3]=1 -> gnt=0 and q=8'h00 immediately, before the next clock edge.
